// File: rtl/bitnet_pkg.sv
// Shared types and helpers for the bitnet training datapath stages.
package bitnet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    CAPTURE,
    BKWD,
    REPORT
  } loss_state_t;

  // Width of a count of set bits in an n-bit vector.
  function automatic int unsigned popcnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Unsigned add clamped to 2^w-1 (w <= 32); callers cast the result to their width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/bit_popcount.sv
// Combinational set-bit counter, shared by the bitnet stages.
module bit_popcount
  import bitnet_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0]           vec,
  output logic [popcnt_w(N)-1:0] count
);

  localparam int unsigned CW = popcnt_w(N);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/fc_loss_seq.sv
// Output/loss stage after the last fc layer: forward settle, capture/compare, backward pass, report.
// Optional macro FC_LOSS_SKIP_MATCH_EN: a perfectly matching sample skips the backward phase.
module fc_loss_seq
  import bitnet_pkg::*;
#(
  parameter int unsigned N         = 9,
  parameter int unsigned FD_CYCLES = 100,
  parameter int unsigned BK_CYCLES = 100,
  parameter int unsigned ERR_W     = popcnt_w(N),
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [N-1:0]     target,
  input  logic [N-1:0]     fout,
  output logic             fd_prop,
  output logic             bk_prop,
  output logic [N-1:0]     bin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [ERR_W-1:0] result_err,
  input  logic             epoch_clr,
  output logic [ACC_W-1:0] epoch_err,
  output logic [ACC_W-1:0] epoch_samples,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (FD_CYCLES > BK_CYCLES) ? FD_CYCLES : BK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  loss_state_t          state;
  loss_state_t          next_state;
  logic [CNT_W-1:0]     cnt;
  logic [N-1:0]         target_q;
  logic [N-1:0]         diff;
  logic [ERR_W-1:0]     err_now;
  logic                 fd_d;
  logic                 bk_d;
  logic                 rv_d;
  logic                 rdy_d;
  logic                 fd_last;
  logic                 bk_last;
  logic                 handshake;
  logic [ACC_W-1:0]     err_base;
  logic [ACC_W-1:0]     smp_base;

  assign diff      = target_q ^ fout;
  assign fd_last   = (cnt == CNT_W'(FD_CYCLES - 1));
  assign bk_last   = (cnt == CNT_W'(BK_CYCLES - 1));
  assign handshake = (state == REPORT) && result_ready;
  assign busy      = (state != IDLE);

  bit_popcount #(.N(N)) u_popcount (
    .vec   (diff),
    .count (err_now)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_ready && sample_valid) next_state = FWD;
      FWD:     if (fd_last) next_state = CAPTURE;
`ifdef FC_LOSS_SKIP_MATCH_EN
      CAPTURE: next_state = (err_now == '0) ? REPORT : BKWD;
`else
      CAPTURE: next_state = BKWD;
`endif
      BKWD:    if (bk_last) next_state = REPORT;
      REPORT:  if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are decoded from next_state so the registered copies track state exactly.
  always_comb begin
    fd_d  = (next_state == FWD);
    bk_d  = (next_state == BKWD);
    rv_d  = (next_state == REPORT);
    rdy_d = (next_state == IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fd_prop      <= 1'b0;
      bk_prop      <= 1'b0;
      result_valid <= 1'b0;
      sample_ready <= 1'b0;
      cnt          <= '0;
      target_q     <= '0;
      bin          <= '0;
      result_err   <= '0;
    end else begin
      fd_prop      <= fd_d;
      bk_prop      <= bk_d;
      result_valid <= rv_d;
      sample_ready <= rdy_d;
      if (state != next_state) begin
        cnt <= '0;
      end else if (state == FWD || state == BKWD) begin
        cnt <= cnt + 1'b1;
      end
      if (state == IDLE && next_state == FWD) begin
        target_q <= target;
      end
      if (state == CAPTURE) begin
        bin        <= ~diff;
        result_err <= err_now;
      end
    end
  end

  // A clear coincident with the handshake restarts the totals from this sample.
  assign err_base = epoch_clr ? '0 : epoch_err;
  assign smp_base = epoch_clr ? '0 : epoch_samples;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      epoch_err     <= '0;
      epoch_samples <= '0;
    end else if (handshake) begin
      epoch_err     <= ACC_W'(sat_add(32'(err_base), 32'(result_err), ACC_W));
      epoch_samples <= ACC_W'(sat_add(32'(smp_base), 32'd1, ACC_W));
    end else if (epoch_clr) begin
      epoch_err     <= '0;
      epoch_samples <= '0;
    end
  end

endmodule

// File: tb/tb_fc_loss_seq.sv
// Self-checking bench for fc_loss_seq (N=9, FD=4, BK=3, ACC_W=4) against a behavioural model.
module tb_fc_loss_seq;

  localparam int N  = 9;
  localparam int FD = 4;
  localparam int BK = 3;
  localparam int AW = 4;
  localparam int EW = 4;
  localparam int ACC_MAX = (1 << AW) - 1;
`ifdef FC_LOSS_SKIP_MATCH_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [N-1:0]  target;
  logic [N-1:0]  fout;
  logic          fd_prop;
  logic          bk_prop;
  logic [N-1:0]  bin;
  logic          result_valid;
  logic          result_ready;
  logic [EW-1:0] result_err;
  logic          epoch_clr;
  logic [AW-1:0] epoch_err;
  logic [AW-1:0] epoch_samples;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int m_err    = 0;
  int m_smp    = 0;

  always #5 clk_in = ~clk_in;

  fc_loss_seq #(
    .N         (N),
    .FD_CYCLES (FD),
    .BK_CYCLES (BK),
    .ACC_W     (AW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .target        (target),
    .fout          (fout),
    .fd_prop       (fd_prop),
    .bk_prop       (bk_prop),
    .bin           (bin),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_err    (result_err),
    .epoch_clr     (epoch_clr),
    .epoch_err     (epoch_err),
    .epoch_samples (epoch_samples),
    .busy          (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_in = 1'b0; sample_valid = 1'b0; result_ready = 1'b0; epoch_clr = 1'b0;
    target = '0; fout = '0;
    #1;
    n_checks++;
    if ({fd_prop, bk_prop, bin, result_valid, result_err, epoch_err, epoch_samples, busy, sample_ready} !== '0)
      $display("FAIL reset_outputs: fd=%b bk=%b bin=%h rv=%b err=%0d ee=%0d es=%0d busy=%b rdy=%b, all required 0",
               fd_prop, bk_prop, bin, result_valid, result_err, epoch_err, epoch_samples, busy, sample_ready);
    else n_pass++;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    n_checks++;
    if (sample_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release_ready: sample_ready=%b busy=%b, required 1/0", sample_ready, busy);
    else n_pass++;
    m_err = 0; m_smp = 0;
  endtask

  // Drives one sample end to end and checks the waveform against the timeline implied by FD/BK.
  task automatic run_sample(input logic [N-1:0] t, input logic [N-1:0] f, input int rdelay,
                            input bit clr_hs, input bit poke_valid, input string tag);
    int werr, lat, waits, bad_fd, bad_bk, bad_rv, bad_hold;
    logic [N-1:0] wbin;
    bit skip_bk, exp_bk;
    werr    = $countones(t ^ f);
    wbin    = ~(t ^ f);
    skip_bk = SKIP && (werr == 0);
    lat     = skip_bk ? FD + 2 : FD + BK + 2;
    waits = 0;
    while (sample_ready !== 1'b1 && waits < 20) begin
      @(negedge clk_in); waits++;
    end
    n_checks++;
    if (sample_ready !== 1'b1) $display("FAIL %s_ready_wait: sample_ready=%b, required 1", tag, sample_ready);
    else n_pass++;
    target = t; fout = f; sample_valid = 1'b1; result_ready = 1'b0;
    bad_fd = 0; bad_bk = 0; bad_rv = 0; bad_hold = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        sample_valid = 1'b0;
        target = N'($urandom);
      end
      exp_bk = !skip_bk && (k >= FD + 2) && (k <= FD + 1 + BK);
      if (fd_prop !== (k <= FD)) bad_fd++;
      if (fd_prop === 1'b1 && bk_prop === 1'b1) bad_fd++;
      if (bk_prop !== exp_bk) bad_bk++;
      if (result_valid !== (k == lat)) bad_rv++;
    end
    n_checks++;
    if (bad_fd != 0) $display("FAIL %s_fd_window: %0d bad cycles, required 0", tag, bad_fd);
    else n_pass++;
    n_checks++;
    if (bad_bk != 0) $display("FAIL %s_bk_window: %0d bad cycles, required 0", tag, bad_bk);
    else n_pass++;
    n_checks++;
    if (bad_rv != 0) $display("FAIL %s_valid_latency: %0d bad cycles, required 0 (latency %0d)", tag, bad_rv, lat);
    else n_pass++;
    n_checks++;
    if (bin !== wbin) $display("FAIL %s_bin: got %h, required %h", tag, bin, wbin);
    else n_pass++;
    n_checks++;
    if (result_err !== EW'(werr)) $display("FAIL %s_result_err: got %0d, required %0d", tag, result_err, werr);
    else n_pass++;
    for (int d = 0; d < rdelay; d++) begin
      if (poke_valid && d == 0) begin
        sample_valid = 1'b1;
        target = N'($urandom);
      end
      @(negedge clk_in);
      sample_valid = 1'b0;
      if (result_valid !== 1'b1 || result_err !== EW'(werr) || sample_ready !== 1'b0 || busy !== 1'b1)
        bad_hold++;
    end
    if (rdelay > 0) begin
      n_checks++;
      if (bad_hold != 0) $display("FAIL %s_backpressure_hold: %0d bad cycles, required 0", tag, bad_hold);
      else n_pass++;
    end
    epoch_clr = clr_hs; result_ready = 1'b1;
    @(negedge clk_in);
    result_ready = 1'b0; epoch_clr = 1'b0;
    if (clr_hs) begin m_err = 0; m_smp = 0; end
    m_err = (m_err + werr > ACC_MAX) ? ACC_MAX : m_err + werr;
    m_smp = (m_smp + 1 > ACC_MAX) ? ACC_MAX : m_smp + 1;
    n_checks++;
    if (result_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0 || fd_prop !== 1'b0)
      $display("FAIL %s_after_handshake: rv=%b rdy=%b busy=%b fd=%b, required 0/1/0/0",
               tag, result_valid, sample_ready, busy, fd_prop);
    else n_pass++;
    n_checks++;
    if (epoch_err !== AW'(m_err) || epoch_samples !== AW'(m_smp))
      $display("FAIL %s_epoch: err=%0d samples=%0d, required %0d/%0d", tag, epoch_err, epoch_samples, m_err, m_smp);
    else n_pass++;
    n_checks++;
    if (bin !== wbin) $display("FAIL %s_bin_hold: got %h, required %h", tag, bin, wbin);
    else n_pass++;
  endtask

  task automatic test_epoch_clr();
    epoch_clr = 1'b1;
    @(negedge clk_in);
    epoch_clr = 1'b0;
    m_err = 0; m_smp = 0;
    n_checks++;
    if (epoch_err !== '0 || epoch_samples !== '0)
      $display("FAIL epoch_clr_idle: err=%0d samples=%0d, required 0/0", epoch_err, epoch_samples);
    else n_pass++;
  endtask

  task automatic test_match();
    run_sample(9'b111000111, 9'b111000111, 0, 1'b0, 1'b0, "match");
  endtask

  task automatic test_mismatch();
    test_epoch_clr();
    run_sample(9'b111000111, 9'b000111000, 0, 1'b0, 1'b0, "mismatch");
  endtask

  task automatic test_backpressure();
    run_sample(N'($urandom), N'($urandom), 5, 1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_saturation();
    test_epoch_clr();
    run_sample(9'h1FF, 9'h000, 0, 1'b0, 1'b0, "sat1");
    run_sample(9'h0F0, 9'h10F, 1, 1'b0, 1'b0, "sat2");
    n_checks++;
    if (epoch_err !== AW'(ACC_MAX)) $display("FAIL saturation_value: got %0d, required %0d", epoch_err, ACC_MAX);
    else n_pass++;
    run_sample(9'h003, 9'h000, 0, 1'b1, 1'b0, "clr_with_hs");
  endtask

  task automatic test_reset_abort();
    int bad;
    while (sample_ready !== 1'b1) @(negedge clk_in);
    target = N'($urandom); fout = N'($urandom); sample_valid = 1'b1;
    @(negedge clk_in);
    sample_valid = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (fd_prop !== 1'b1) $display("FAIL abort_fd_before: fd_prop=%b, required 1", fd_prop);
    else n_pass++;
    rst_in = 1'b0;
    #1;
    n_checks++;
    if ({fd_prop, bk_prop, bin, result_valid, result_err, epoch_err, epoch_samples, busy, sample_ready} !== '0)
      $display("FAIL abort_async_clear: fd=%b bk=%b bin=%h rv=%b err=%0d ee=%0d es=%0d busy=%b rdy=%b, all required 0",
               fd_prop, bk_prop, bin, result_valid, result_err, epoch_err, epoch_samples, busy, sample_ready);
    else n_pass++;
    @(negedge clk_in);
    rst_in = 1'b1;
    m_err = 0; m_smp = 0;
    @(negedge clk_in);
    n_checks++;
    if (sample_ready !== 1'b1) $display("FAIL abort_ready_after_release: got %b, required 1", sample_ready);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_in);
      if (result_valid !== 1'b0 || fd_prop !== 1'b0 || bk_prop !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_no_result: %0d active cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_skip_match();
    run_sample(9'h0A5, 9'h0A5, 0, 1'b0, 1'b0, "skip_match");
  endtask

  task automatic test_random();
    logic [N-1:0] t, mask;
    for (int i = 0; i < 20; i++) begin
      t = N'($urandom);
      case ($urandom_range(0, 3))
        0:       mask = '0;
        1:       mask = N'(1) << $urandom_range(0, N - 1);
        2:       mask = N'($urandom);
        default: mask = '1;
      endcase
      run_sample(t, t ^ mask, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1) == 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_backpressure();
    test_saturation();
    test_reset_abort();
    test_skip_match();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
